// File: rtl/fizzbuzz_pkg.sv
// Shared types, constants and helpers for the fizzbuzz stream checker.
package fizzbuzz_pkg;

   typedef enum logic {
      chk_idle,
      chk_locked
   } chk_state_t;

   localparam int unsigned c_fizz_mod = 3;
   localparam int unsigned c_buzz_mod = 5;

   // Counters up to 32 bits pass through this helper zero-extended.
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] max_value);
      return (value == max_value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/fizzbuzz_ref_model.sv
// Reference sequence generator: expected number plus wrapping mod-3/mod-5
// counters that yield the expected fizz/buzz flags without division.
module fizzbuzz_ref_model
   import fizzbuzz_pkg::*;
#(
   parameter int unsigned g_length = 20
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_advance,
   input  logic                            i_restart,
   output logic [$clog2(g_length+1)-1:0]   o_exp_number,
   output logic                            o_exp_fizz,
   output logic                            o_exp_buzz
);

   localparam int unsigned c_num_w = $clog2(g_length + 1);
   localparam int unsigned c_m3_w  = $clog2(c_fizz_mod);
   localparam int unsigned c_m5_w  = $clog2(c_buzz_mod);

   logic [c_num_w-1:0] num_q, num_d;
   logic [c_m3_w-1:0]  mod3_q, mod3_d;
   logic [c_m5_w-1:0]  mod5_q, mod5_d;

   always_comb begin
      num_d  = num_q;
      mod3_d = mod3_q;
      mod5_d = mod5_q;
      if (i_restart || (i_advance && (num_q == c_num_w'(g_length)))) begin
         num_d  = c_num_w'(1);
         mod3_d = c_m3_w'(1);
         mod5_d = c_m5_w'(1);
      end else if (i_advance) begin
         num_d  = num_q + c_num_w'(1);
         mod3_d = (mod3_q == c_m3_w'(c_fizz_mod - 1)) ? '0 : mod3_q + c_m3_w'(1);
         mod5_d = (mod5_q == c_m5_w'(c_buzz_mod - 1)) ? '0 : mod5_q + c_m5_w'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         num_q  <= c_num_w'(1);
         mod3_q <= c_m3_w'(1);
         mod5_q <= c_m5_w'(1);
      end else begin
         num_q  <= num_d;
         mod3_q <= mod3_d;
         mod5_q <= mod5_d;
      end
   end

   assign o_exp_number = num_q;
   assign o_exp_fizz   = (mod3_q == '0);
   assign o_exp_buzz   = (mod5_q == '0);

endmodule

// File: rtl/fizzbuzz_checker.sv
// In-system checker for a fizzbuzz stream: locks onto beat 1, flags number
// and flag mismatches, and keeps a sticky error plus saturating counters.
module fizzbuzz_checker
   import fizzbuzz_pkg::*;
#(
   parameter int unsigned g_length    = 20,
   parameter int unsigned g_cnt_width = 16
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_clr,
   input  logic                            i_valid,
   input  logic [$clog2(g_length+1)-1:0]   i_number,
   input  logic                            i_is_fizz,
   input  logic                            i_is_buzz,
   output logic                            o_locked,
   output logic                            o_err,
   output logic                            o_err_num,
   output logic                            o_err_sticky,
   output logic [g_cnt_width-1:0]          o_beat_cnt,
   output logic [g_cnt_width-1:0]          o_err_cnt
);

   localparam int unsigned c_num_w = $clog2(g_length + 1);
   localparam logic [g_cnt_width-1:0] c_cnt_max = '1;

   chk_state_t             state_q, state_d;
   logic                   err_q, err_d;
   logic                   err_num_q, err_num_d;
   logic                   sticky_q;
   logic [g_cnt_width-1:0] beat_cnt_q, err_cnt_q;

   logic               advance, restart, count_beat;
   logic               num_ok, flag_ok;
   logic [c_num_w-1:0] exp_number;
   logic               exp_fizz, exp_buzz;

   fizzbuzz_ref_model #(
      .g_length (g_length)
   ) u_ref (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_advance    (advance),
      .i_restart    (restart),
      .o_exp_number (exp_number),
      .o_exp_fizz   (exp_fizz),
      .o_exp_buzz   (exp_buzz)
   );

   assign num_ok  = (i_number == exp_number);
   assign flag_ok = (i_is_fizz == exp_fizz) && (i_is_buzz == exp_buzz);

   // In idle the reference always sits at 1, so num_ok means "beat is 1".
   always_comb begin
      state_d    = state_q;
      err_d      = 1'b0;
      err_num_d  = 1'b0;
      advance    = 1'b0;
      restart    = 1'b0;
      count_beat = 1'b0;
      if (i_clr) begin
         state_d = chk_idle;
         restart = 1'b1;
      end else if (i_valid) begin
         case (state_q)
            chk_idle: begin
               if (num_ok) begin
                  state_d    = chk_locked;
                  advance    = 1'b1;
                  count_beat = 1'b1;
                  err_d      = !flag_ok;
               end else begin
                  err_d     = 1'b1;
                  err_num_d = 1'b1;
               end
            end
            chk_locked: begin
               count_beat = 1'b1;
               if (!num_ok) begin
                  state_d   = chk_idle;
                  restart   = 1'b1;
                  err_d     = 1'b1;
                  err_num_d = 1'b1;
               end else begin
                  advance = 1'b1;
                  err_d   = !flag_ok;
               end
            end
            default: state_d = chk_idle;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= chk_idle;
         err_q      <= 1'b0;
         err_num_q  <= 1'b0;
         sticky_q   <= 1'b0;
         beat_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         err_num_q <= err_num_d;
         if (i_clr) begin
            sticky_q   <= 1'b0;
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
         end else begin
            sticky_q <= sticky_q | err_d;
            if (count_beat)
               beat_cnt_q <= g_cnt_width'(sat_inc(32'(beat_cnt_q), 32'(c_cnt_max)));
            if (err_d)
               err_cnt_q <= g_cnt_width'(sat_inc(32'(err_cnt_q), 32'(c_cnt_max)));
         end
      end
   end

   assign o_locked     = (state_q == chk_locked);
   assign o_err        = err_q;
   assign o_err_num    = err_num_q;
   assign o_err_sticky = sticky_q;
   assign o_beat_cnt   = beat_cnt_q;
   assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fizzbuzz_checker.sv
// Directed bench for fizzbuzz_checker with an arithmetic reference model and
// a second instance using 2-bit counters to exercise saturation.
module tb_fizzbuzz_checker;

   localparam int unsigned LEN = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       valid = 1'b0;
   logic [4:0] number = '0;
   logic       fizz = 1'b0;
   logic       buzz = 1'b0;

   logic        o_locked, o_err, o_err_num, o_sticky;
   logic [15:0] o_beat_cnt, o_err_cnt;
   logic        s_locked, s_err, s_err_num, s_sticky;
   logic [1:0]  s_beat_cnt, s_err_cnt;

   int nchk  = 0;
   int nfail = 0;

   fizzbuzz_checker #(.g_length(LEN), .g_cnt_width(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(valid),
      .i_number(number), .i_is_fizz(fizz), .i_is_buzz(buzz),
      .o_locked(o_locked), .o_err(o_err), .o_err_num(o_err_num),
      .o_err_sticky(o_sticky), .o_beat_cnt(o_beat_cnt), .o_err_cnt(o_err_cnt)
   );

   fizzbuzz_checker #(.g_length(LEN), .g_cnt_width(2)) dut_sat (
      .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(valid),
      .i_number(number), .i_is_fizz(fizz), .i_is_buzz(buzz),
      .o_locked(s_locked), .o_err(s_err), .o_err_num(s_err_num),
      .o_err_sticky(s_sticky), .o_beat_cnt(s_beat_cnt), .o_err_cnt(s_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: unbounded counters, flags from plain modulo arithmetic.
   int m_exp = 1, m_beat = 0, m_errc = 0;
   bit m_locked = 0, m_err = 0, m_err_num = 0, m_sticky = 0;
   bit m_nok, m_fok;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_exp = 1; m_beat = 0; m_errc = 0;
         m_locked = 0; m_err = 0; m_err_num = 0; m_sticky = 0;
      end else begin
         m_err = 0;
         m_err_num = 0;
         if (clr) begin
            m_exp = 1; m_beat = 0; m_errc = 0; m_locked = 0; m_sticky = 0;
         end else if (valid) begin
            m_nok = (int'(number) == m_exp);
            m_fok = (fizz == (m_exp % 3 == 0)) && (buzz == (m_exp % 5 == 0));
            if (!m_nok) begin
               m_err = 1; m_err_num = 1;
               if (m_locked) m_beat++;
               m_locked = 0; m_exp = 1;
            end else begin
               m_beat++;
               m_locked = 1;
               m_err = !m_fok;
               m_exp = (m_exp == LEN) ? 1 : m_exp + 1;
            end
            if (m_err) m_errc++;
            m_sticky = m_sticky | m_err;
         end
      end
   end

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   always @(negedge clk) begin
      chk("locked",       int'(o_locked),   int'(m_locked));
      chk("err",          int'(o_err),      int'(m_err));
      chk("err_num",      int'(o_err_num),  int'(m_err_num));
      chk("sticky",       int'(o_sticky),   int'(m_sticky));
      chk("beat_cnt",     int'(o_beat_cnt), sat(m_beat, 65535));
      chk("err_cnt",      int'(o_err_cnt),  sat(m_errc, 65535));
      chk("sat_locked",   int'(s_locked),   int'(m_locked));
      chk("sat_beat_cnt", int'(s_beat_cnt), sat(m_beat, 3));
      chk("sat_err_cnt",  int'(s_err_cnt),  sat(m_errc, 3));
   end

   // Drives one beat; returns #1 after the edge that sampled it.
   task automatic send(input int n, input bit f, input bit b);
      valid = 1'b1; number = 5'(n); fizz = f; buzz = b;
      @(posedge clk); #1;
   endtask

   task automatic send_good(input int n);
      send(n, (n % 3) == 0, (n % 5) == 0);
   endtask

   task automatic idle(input int k);
      valid = 1'b0;
      repeat (k) begin @(posedge clk); #1; end
   endtask

   task automatic do_clr();
      valid = 1'b0; clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_locked",   int'(o_locked),   0);
      chk("rst_beat_cnt", int'(o_beat_cnt), 0);
      chk("rst_sticky",   int'(o_sticky),   0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Clean stream 1..20 then 1..5, back to back
      send_good(1);
      chk("lock_after_first", int'(o_locked), 1);
      for (int n = 2; n <= 20; n++) send_good(n);
      for (int n = 1; n <= 5; n++) send_good(n);
      idle(1);
      chk("clean_beat_cnt", int'(o_beat_cnt), 25);
      chk("clean_err_cnt",  int'(o_err_cnt),  0);
      chk("clean_sticky",   int'(o_sticky),   0);
      chk("clean_sat_beat", int'(s_beat_cnt), 3);
      chk("model_clean",    m_beat,           25);

      do_clr();
      chk("clr_beat_cnt", int'(o_beat_cnt), 0);
      chk("clr_locked",   int'(o_locked),   0);

      // Gapped stream
      for (int n = 1; n <= 10; n++) begin
         send_good(n);
         idle(2);
      end
      chk("gap_beat_cnt", int'(o_beat_cnt), 10);
      chk("gap_err_cnt",  int'(o_err_cnt),  0);

      // Flag-only error on beat 9
      do_clr();
      for (int n = 1; n <= 8; n++) send_good(n);
      send(9, 1'b0, 1'b0);
      chk("flag_err",     int'(o_err),     1);
      chk("flag_err_num", int'(o_err_num), 0);
      chk("flag_err_cnt", int'(o_err_cnt), 1);
      chk("flag_locked",  int'(o_locked),  1);
      send_good(10);
      chk("flag_next_clean", int'(o_err), 0);
      chk("model_flag_errc", m_errc,      1);
      idle(1);

      // Number error 1,2,3,5 then 7 in idle, then relock
      do_clr();
      send_good(1); send_good(2); send_good(3);
      send_good(5);
      chk("num_err_num", int'(o_err_num), 1);
      chk("num_locked",  int'(o_locked),  0);
      send_good(7);
      chk("idle_err_num", int'(o_err_num), 1);
      chk("idle_locked",  int'(o_locked),  0);
      send_good(1);
      chk("relock",         int'(o_locked),  1);
      chk("relock_err_cnt", int'(o_err_cnt), 2);
      chk("relock_err",     int'(o_err),     0);
      idle(1);

      // Asynchronous reset mid-stream
      do_clr();
      for (int n = 1; n <= 11; n++) send_good(n);
      chk("pre_rst_beat", int'(o_beat_cnt), 11);
      valid = 1'b1; number = 5'd12; fizz = 1'b1; buzz = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_locked",   int'(o_locked),   0);
      chk("async_beat_cnt", int'(o_beat_cnt), 0);
      valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      send_good(1); send_good(2); send_good(3);
      chk("post_rst_locked", int'(o_locked),   1);
      chk("post_rst_beat",   int'(o_beat_cnt), 3);
      chk("post_rst_err",    int'(o_err_cnt),  0);

      // Clear coincident with an erroneous beat
      send(2, 1'b0, 1'b0);
      chk("pre_clr_sticky", int'(o_sticky), 1);
      clr = 1'b1;
      send(9, 1'b1, 1'b0);
      clr = 1'b0; valid = 1'b0;
      chk("clr_beat_err",     int'(o_err),     0);
      chk("clr_beat_sticky",  int'(o_sticky),  0);
      chk("clr_beat_err_cnt", int'(o_err_cnt), 0);
      chk("clr_beat_locked",  int'(o_locked),  0);

      // Saturation of the 2-bit error counter
      for (int i = 0; i < 5; i++) send(7, 1'b0, 1'b0);
      idle(1);
      chk("sat_err_cnt_lit", int'(s_err_cnt), 3);
      chk("wide_err_cnt_5",  int'(o_err_cnt), 5);
      chk("sat_sticky",      int'(s_sticky),  1);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/fizzbuzz_checker.md
Name: fizzbuzz_checker

Overview:
Consumer end of the fizzbuzz stream. Receives one beat per valid cycle (number, fizz flag, buzz flag) and checks it against an internal reference sequence. Reports per-beat error pulses, a sticky error, and saturating beat/error counters. Sits downstream of the fizzbuzz generator as an in-system checker, and doubles as a scoreboard in benches.

Parameters:
g_length, 20, last number of the sequence; expected numbers run 1..g_length, then wrap to 1.
g_cnt_width, 16, width of the beat and error counters.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_clr  in  1  synchronous clear of counters, sticky error and lock state
i_valid  in  1  beat qualifier
i_number  in  $clog2(g_length+1)  received number
i_is_fizz  in  1  received fizz flag
i_is_buzz  in  1  received buzz flag
o_locked  out  1  checker is tracking the sequence
o_err  out  1  one-cycle pulse: previous beat mismatched
o_err_num  out  1  one-cycle pulse: number mismatch (subset of o_err)
o_err_sticky  out  1  set on any error; cleared by i_rst or i_clr
o_beat_cnt  out  g_cnt_width  beats accepted while locked (saturating)
o_err_cnt  out  g_cnt_width  erroneous beats (saturating)

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0; expected number 1; mod3 = 1, mod5 = 1.
- Expected flags: fizz = (mod3 == 0), buzz = (mod5 == 0). mod3/mod5 are wrapping counters (0..2, 0..4) advanced with the expected number. No dividers.
- State IDLE:
  - Valid beat with i_number == 1 and correct flags (0,0): go to LOCKED; expected becomes 2.
  - Valid beat with i_number == 1 and wrong flags: go to LOCKED; flag error.
  - Valid beat with i_number != 1: error with o_err_num; stay IDLE.
- State LOCKED, valid beat:
  - Number mismatch: o_err, o_err_num; return to IDLE; expected reset to 1.
  - Flag-only mismatch: o_err; stay LOCKED and advance.
  - Match: advance only.
  - Advance: if expected == g_length, next expected is 1 with mod3 = mod5 = 1; else expected+1 with mod3/mod5 incremented with wrap.
- i_valid = 0: no state, counter or expected-value change; o_err = o_err_num = 0.
- Latency: o_err, o_err_num and counter updates are registered, visible on the cycle after the beat. o_err_sticky rises in that same cycle.
- o_beat_cnt increments on every valid beat checked in LOCKED, and on the IDLE beat that locks. o_err_cnt increments on every erroneous beat. Both hold at all-ones.
- i_clr and i_valid in the same cycle: clear wins. The beat is ignored, state returns to IDLE, counters and sticky go to 0, and no error is reported.
- Reset mid-stream: immediate return to reset values. The next beat must be 1 to relock.
- Number width is $clog2(g_length+1), so g_length itself is representable. Compare full width; no truncation.

Decomposition:
- fizzbuzz_pkg holds:
  - chk_state_t enum {chk_idle, chk_locked}
  - constants c_fizz_mod = 3, c_buzz_mod = 5
  - function for saturating increment
- Sub-module fizzbuzz_ref_model holds the expected number plus the mod3/mod5 counters.
  - Inputs: advance, restart.
  - Outputs: exp_number, exp_fizz, exp_buzz.
- The top level holds the FSM, comparison, counters and sticky flag.

Test Plan:
- Clean stream 1..20, then 1..5 (25 beats, valid every cycle), fizz on 3,6,9,12,15,18 and buzz on 5,10,15,20 -> o_locked = 1 after the first beat; o_err never pulses; o_beat_cnt = 25; o_err_cnt = 0.
- Clean stream with i_valid gaps (valid 1 of every 3 cycles, numbers 1..10) -> identical result to back-to-back; o_beat_cnt = 10.
- Beat 9 sent with fizz = 0 -> o_err = 1 and o_err_num = 0 one cycle later; o_err_cnt = 1; o_locked stays 1; beat 10 checks clean.
- Sequence 1,2,3,5 -> o_err_num pulses after beat 5; o_locked = 0; subsequent 7 errors (IDLE); then 1 relocks with o_err_cnt = 2.
- i_rst asserted asynchronously mid-stream at beat 12 -> outputs 0 without waiting for a clock edge; stream restarting at 1 locks cleanly.
- i_clr coincident with an erroneous beat -> o_err stays 0; o_err_sticky = 0; o_err_cnt = 0; o_locked = 0. With g_cnt_width = 2, after 5 errors o_err_cnt = 3 (saturated).
